// File: rtl/spell_link_pkg.sv
// Shared encodings for the spell CPU host link: command fields, debug-port bit indices, FSM states.
package spell_link_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_RUN    = 2'b01,
        OP_DUMP   = 2'b10,
        OP_STATUS = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        SEL_PC    = 2'd0,
        SEL_SP    = 2'd1,
        SEL_EXEC  = 2'd2,
        SEL_STACK = 2'd3
    } reg_sel_t;

    localparam int UI_RUN    = 0;
    localparam int UI_STEP   = 1;
    localparam int UI_LOAD   = 2;
    localparam int UI_DUMP   = 3;
    localparam int UI_SHIFT  = 4;
    localparam int UI_SEL_LO = 5;
    localparam int UI_SEL_HI = 6;

    localparam int ST_SHIFT_OUT = 3;

    localparam int TMR_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GETDATA,
        S_SHIFT,
        S_LOAD,
        S_DUMP,
        S_CAPTURE,
        S_RUN,
        S_RESP
    } state_t;

    function automatic op_t cmd_op(input logic [7:0] cmd);
        return op_t'(cmd[7:6]);
    endfunction

endpackage

// File: rtl/spell_link_serdes.sv
// 8-bit shift/capture register with a 3-bit bit counter; bit_out is the MSB the register will hold next
// cycle, so the caller can register it into the debug port in step with the shift.
module spell_link_serdes (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_capture,
    input  logic [7:0] i_data,
    input  logic       i_bit_in,
    output logic       o_bit_out,
    output logic [7:0] o_data,
    output logic       o_done
);

    logic [7:0] r_sr;
    logic [7:0] w_sr_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;

    always_comb begin
        w_sr_nxt  = r_sr;
        w_cnt_nxt = r_cnt;
        if (i_load) begin
            w_sr_nxt  = i_data;
            w_cnt_nxt = '0;
        end else if (i_capture) begin
            w_sr_nxt  = {r_sr[6:0], i_bit_in};
            w_cnt_nxt = r_cnt + 3'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else begin
            r_sr  <= w_sr_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_bit_out = w_sr_nxt[7];
    assign o_data    = r_sr;
    assign o_done    = (r_cnt == 3'd7);

endmodule

// File: rtl/spell_host_link.sv
// Byte-command engine driving the spell CPU debug port; replies to DUMP/STATUS on a response stream.
// Optional SPELL_HOST_LINK_BURST_EN: LOAD takes cmd[3:0]+1 data bytes.
//
// state    | meaning
// IDLE     | waiting for a command byte
// GETDATA  | waiting for a LOAD data byte
// SHIFT    | 8 cycles of data bits on shift_in, MSB first
// LOAD     | one-cycle load pulse with reg_sel
// DUMP     | one-cycle dump pulse with reg_sel
// CAPTURE  | collect shift_out bits (DUMP) or the status nibble (STATUS)
// RUN      | run/step held RUN_HOLD cycles, then one idle cycle
// RESP     | response byte offered until accepted
module spell_host_link
    import spell_link_pkg::*;
#(
    parameter int RUN_HOLD = 2,
    parameter int DUMP_LAT = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_cmd_data,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output logic [7:0] o_cpu_ui,
    input  logic [3:0] i_cpu_status,
    output logic       o_busy
);

    state_t           r_state, w_state_nxt;
    op_t              r_op, w_op_nxt;
    reg_sel_t         r_sel, w_sel_nxt;
    logic             r_step, w_step_nxt;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic [7:0]       r_cpu_ui, w_ui_nxt;
    logic             r_rsp_valid;
    logic             r_busy;
    logic             w_cmd_fire;

    logic             w_sd_load;
    logic             w_sd_capture;
    logic [7:0]       w_sd_din;
    logic             w_sd_bit_out;
    logic [7:0]       w_sd_dout;
    logic             w_sd_done;

`ifdef SPELL_HOST_LINK_BURST_EN
    logic [3:0]       r_left, w_left_nxt;
`else
    logic             w_unused_cmd_bits;
    assign w_unused_cmd_bits = ^i_cmd_data[3:1];
`endif

    assign o_cmd_ready = (r_state == S_IDLE) || (r_state == S_GETDATA);
    assign w_cmd_fire  = i_cmd_valid && o_cmd_ready;

    spell_link_serdes u_serdes (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_sd_load),
        .i_capture (w_sd_capture),
        .i_data    (w_sd_din),
        .i_bit_in  (i_cpu_status[ST_SHIFT_OUT]),
        .o_bit_out (w_sd_bit_out),
        .o_data    (w_sd_dout),
        .o_done    (w_sd_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LOAD;
            r_sel       <= SEL_PC;
            r_step      <= 1'b0;
            r_tmr       <= '0;
            r_cpu_ui    <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SPELL_HOST_LINK_BURST_EN
            r_left      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_sel       <= w_sel_nxt;
            r_step      <= w_step_nxt;
            r_tmr       <= w_tmr_nxt;
            r_cpu_ui    <= w_ui_nxt;
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_busy      <= (w_state_nxt != S_IDLE);
`ifdef SPELL_HOST_LINK_BURST_EN
            r_left      <= w_left_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_sel_nxt    = r_sel;
        w_step_nxt   = r_step;
        w_tmr_nxt    = r_tmr;
        w_sd_load    = 1'b0;
        w_sd_capture = 1'b0;
        w_sd_din     = '0;
`ifdef SPELL_HOST_LINK_BURST_EN
        w_left_nxt   = r_left;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    w_op_nxt   = cmd_op(i_cmd_data);
                    w_sel_nxt  = reg_sel_t'(i_cmd_data[5:4]);
                    w_step_nxt = i_cmd_data[0];
`ifdef SPELL_HOST_LINK_BURST_EN
                    w_left_nxt = i_cmd_data[3:0];
`endif
                    case (cmd_op(i_cmd_data))
                        OP_LOAD: w_state_nxt = S_GETDATA;
                        OP_RUN: begin
                            w_state_nxt = S_RUN;
                            w_tmr_nxt   = TMR_W'(RUN_HOLD);
                        end
                        OP_DUMP: begin
                            // clears the bit counter ahead of the capture window
                            w_state_nxt = S_DUMP;
                            w_sd_load   = 1'b1;
                        end
                        default: w_state_nxt = S_CAPTURE;
                    endcase
                end
            end
            S_GETDATA: begin
                if (w_cmd_fire) begin
                    w_sd_load   = 1'b1;
                    w_sd_din    = i_cmd_data;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_sd_capture = 1'b1;
                if (w_sd_done) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef SPELL_HOST_LINK_BURST_EN
                if (r_left != 4'd0) begin
                    w_left_nxt  = r_left - 4'd1;
                    w_state_nxt = S_GETDATA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            S_DUMP: begin
                w_tmr_nxt   = TMR_W'(DUMP_LAT - 1);
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (r_op == OP_STATUS) begin
                    w_sd_load   = 1'b1;
                    w_sd_din    = {4'b0000, i_cpu_status};
                    w_state_nxt = S_RESP;
                end else if (r_tmr != '0) begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end else begin
                    w_sd_capture = 1'b1;
                    if (w_sd_done) begin
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_RUN: begin
                if (r_tmr == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmr_nxt = r_tmr - TMR_W'(1);
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Debug-port value for the cycle the FSM is about to enter, so cpu_ui lines up with the state.
    always_comb begin
        w_ui_nxt = '0;
        case (w_state_nxt)
            S_SHIFT: w_ui_nxt[UI_SHIFT] = w_sd_bit_out;
            S_LOAD: begin
                w_ui_nxt[UI_LOAD]             = 1'b1;
                w_ui_nxt[UI_SEL_HI:UI_SEL_LO] = w_sel_nxt;
            end
            S_DUMP: begin
                w_ui_nxt[UI_DUMP]             = 1'b1;
                w_ui_nxt[UI_SEL_HI:UI_SEL_LO] = w_sel_nxt;
            end
            S_RUN: begin
                // the last RUN cycle (timer at zero) is the idle gap before the next rising edge
                if (w_tmr_nxt != '0) begin
                    w_ui_nxt[UI_RUN]  = 1'b1;
                    w_ui_nxt[UI_STEP] = w_step_nxt;
                end
            end
            default: w_ui_nxt = '0;
        endcase
    end

    assign o_cpu_ui    = r_cpu_ui;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = w_sd_dout;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_spell_host_link.sv
// Directed and random bench for spell_host_link against a small spell CPU debug-port model.
module tb_spell_host_link;

    localparam int RUN_HOLD = 2;
    localparam int DUMP_LAT = 2;

    logic       clk;
    logic       rst;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] cpu_ui;
    logic [3:0] cpu_status;
    logic       busy;

    logic [2:0] status_lo;
    logic       w_shift_bit;

    int total = 0;
    int bad   = 0;

    // CPU model state
    logic [7:0] m_sr   = 8'h00;
    logic [7:0] m_pc   = 8'h00;
    logic [7:0] m_sp   = 8'h00;
    logic [7:0] m_exec = 8'h00;
    logic [7:0] m_stk [256];
    logic [7:0] dump_val = 8'h00;
    int         dump_age = 0;
    logic       prev_run = 1'b0;
    int         run_rises = 0;
    int         load_pulses = 0;

    spell_host_link #(.RUN_HOLD(RUN_HOLD), .DUMP_LAT(DUMP_LAT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_data   (cmd_data),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_cpu_ui     (cpu_ui),
        .i_cpu_status (cpu_status),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        w_shift_bit = 1'b0;
        if (dump_age >= DUMP_LAT && dump_age <= DUMP_LAT + 7)
            w_shift_bit = dump_val[7 - (dump_age - DUMP_LAT)];
    end
    assign cpu_status = {w_shift_bit, status_lo};

    always @(posedge clk) begin
        m_sr     <= {m_sr[6:0], cpu_ui[4]};
        prev_run <= cpu_ui[0];
        if (cpu_ui[0] && !prev_run) run_rises <= run_rises + 1;
        if (cpu_ui[2]) begin
            load_pulses <= load_pulses + 1;
            case (cpu_ui[6:5])
                2'd0: m_pc <= m_sr;
                2'd1: m_sp <= m_sr;
                2'd2: m_exec <= m_sr;
                default: begin
                    m_stk[m_sp] <= m_sr;
                    m_sp        <= m_sp + 8'd1;
                end
            endcase
        end
        if (cpu_ui[3]) begin
            dump_age <= 1;
            case (cpu_ui[6:5])
                2'd0: dump_val <= m_pc;
                2'd1: dump_val <= m_sp;
                2'd2: dump_val <= m_exec;
                default: dump_val <= m_stk[m_sp - 8'd1];
            endcase
        end else if (dump_age != 0 && dump_age < 40) begin
            dump_age <= dump_age + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept_timeout", 32'(n < 100), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 100), 1);
    endtask

    task automatic get_rsp(output logic [7:0] d);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", 32'(n < 200), 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        d = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_single", 32'(rsp_valid), 0);
    endtask

    initial begin
        logic [7:0] exp_reg [4];
        logic [7:0] d;
        logic [7:0] dv;
        logic [7:0] st_exp;
        logic [1:0] sel;
        logic       step;
        int         kind;
        int         r0;
        int         p0;
        int         seen_rsp;
        int         seen_ui;

        for (int i = 0; i < 4; i++) exp_reg[i] = 8'h00;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        status_lo = 3'b000;
        repeat (3) @(negedge clk);
        chk("reset_ui", 32'(cpu_ui), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 1);

        // LOAD PC with 0x2A: exact shift sequence and single load pulse
        dv = 8'h2A;
        send_byte(8'h00);
        send_byte(dv);
        for (int k = 0; k < 8; k++) begin
            chk("t1_shift", 32'(cpu_ui), 32'({3'b000, dv[7 - k], 4'b0000}));
            @(negedge clk);
        end
        chk("t1_load", 32'(cpu_ui), 32'h04);
        chk("t1_no_rsp", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("t1_after", 32'(cpu_ui), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_pc_model", 32'(m_pc), 32'h2A);
        exp_reg[0] = dv;

        // load SP = 0x13, then DUMP SP
        send_byte(8'h10);
        send_byte(8'h13);
        wait_idle();
        exp_reg[1] = 8'h13;
        send_byte(8'h90);
        get_rsp(d);
        chk("t2_dump_sp", 32'(d), 32'h13);

        // RUN with step: held RUN_HOLD cycles, then a zero cycle; two rising edges for two commands
        r0 = run_rises;
        for (int rep = 0; rep < 2; rep++) begin
            send_byte(8'h41);
            for (int j = 0; j < RUN_HOLD; j++) begin
                chk("t3_run_hi", 32'(cpu_ui), 32'h03);
                @(negedge clk);
            end
            chk("t3_run_gap", 32'(cpu_ui), 0);
            wait_idle();
        end
        chk("t3_rises", 32'(run_rises), 32'(r0 + 2));

        // STATUS under backpressure
        status_lo = 3'b101;
        st_exp    = 8'h05;
        send_byte(8'hC0);
        for (int n = 0; n < 20 && rsp_valid !== 1'b1; n++) @(negedge clk);
        status_lo = 3'b010;
        for (int j = 0; j < 5; j++) begin
            chk("t4_hold_valid", 32'(rsp_valid), 1);
            chk("t4_hold_data", 32'(rsp_data), 32'(st_exp));
            chk("t4_hold_cmd_ready", 32'(cmd_ready), 0);
            @(negedge clk);
        end
        get_rsp(d);
        chk("t4_status", 32'(d), 32'(st_exp));

        // reset in the 4th SHIFT cycle abandons the LOAD
        send_byte(8'h00);
        send_byte(8'hFF);
        repeat (3) @(negedge clk);
        p0  = load_pulses;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_ui_zero", 32'(cpu_ui), 0);
        chk("t5_cmd_ready", 32'(cmd_ready), 1);
        chk("t5_busy", 32'(busy), 0);
        seen_rsp = 0;
        seen_ui  = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen_rsp++;
            if (cpu_ui !== 8'h00) seen_ui++;
        end
        chk("t5_no_load", 32'(load_pulses), 32'(p0));
        chk("t5_no_rsp", 32'(seen_rsp), 0);
        chk("t5_ui_quiet", 32'(seen_ui), 0);
        send_byte(8'h80);
        get_rsp(d);
        chk("t5_pc_kept", 32'(d), 32'(exp_reg[0]));

`ifdef SPELL_HOST_LINK_BURST_EN
        // burst push of three bytes onto the stack
        p0 = load_pulses;
        send_byte(8'h32);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        wait_idle();
        chk("t6_pulses", 32'(load_pulses), 32'(p0 + 3));
        exp_reg[1] = exp_reg[1] + 8'd3;
        send_byte(8'h90);
        get_rsp(d);
        chk("t6_sp", 32'(d), 32'(exp_reg[1]));
        send_byte(8'hB0);
        get_rsp(d);
        chk("t6_stack_top", 32'(d), 32'h33);
`endif

        // random mix of LOAD / DUMP / RUN / STATUS against the register map
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            sel  = 2'($urandom_range(0, 2));
            dv   = 8'($urandom);
            case (kind)
                0: begin
                    send_byte({2'b00, sel, 4'h0});
                    send_byte(dv);
                    wait_idle();
                    exp_reg[sel] = dv;
                end
                1: begin
                    send_byte({2'b10, sel, 4'h0});
                    get_rsp(d);
                    chk("rnd_dump", 32'(d), 32'(exp_reg[sel]));
                end
                2: begin
                    step = 1'($urandom);
                    send_byte({2'b01, 2'b00, 3'b000, step});
                    for (int j = 0; j < RUN_HOLD; j++) begin
                        chk("rnd_run_hi", 32'(cpu_ui), 32'({6'b000000, step, 1'b1}));
                        @(negedge clk);
                    end
                    chk("rnd_run_gap", 32'(cpu_ui), 0);
                    wait_idle();
                end
                default: begin
                    status_lo = 3'($urandom);
                    st_exp    = {5'b00000, status_lo};
                    send_byte(8'hC0);
                    get_rsp(d);
                    chk("rnd_status", 32'(d), 32'(st_exp));
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
